in_controller: RTL and testbench



---
 rtl/in_controller_pkg.sv | 19 +
 rtl/in_controller.sv | 134 +++++++++++++
 tb/tb_in_controller.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/in_controller_pkg.sv
// Shared types and defaults for the `in` instruction controller.
// Holds the default commit-ring width, the receive buffer width and the
// controller FSM state encoding.
package in_controller_pkg;

  // log2 of the commit-ring depth; sets tag and rollback-count width.
  localparam int DEFAULT_COMMIT_RING_WIDTH = 4;

  // log2 of the UART receive word buffer depth.
  localparam int IN_BUFFER_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RX  = 2'd1,
    RESULT   = 2'd2,
    ROLLBACK = 2'd3
  } in_ctrl_state_t;

endpackage

// File: rtl/in_controller.sv
// Purpose: sequences speculative `in` reads against the UART receive word
//   buffer, tracks popped-but-uncommitted words and drives the buffer
//   rollback on a misprediction flush.
// Latency: request accept at N, pop no earlier than N+1, result valid the
//   cycle after the pop; rollback pulse the cycle after flush.
// Backpressure: one request in flight; req_ready drops while busy or when
//   the speculative count is saturated; result held until res_grant.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   req_valid/req_tag/req_ready   issue-side request handshake
//   rx_data/rx_valid/rx_ready     receive buffer pop handshake
//   res_valid/res_tag/res_data/res_grant  result to the CDB arbiter
//   commit, flush           commit-ring retire and misprediction squash
//   rx_rollback/rx_in_count receive buffer rewind request and amount
module in_controller
  import in_controller_pkg::*;
#(
  parameter int COMMIT_RING_WIDTH = DEFAULT_COMMIT_RING_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_valid,
  input  logic [COMMIT_RING_WIDTH-1:0] req_tag,
  output logic                         req_ready,
  input  logic [31:0]                  rx_data,
  input  logic                         rx_valid,
  output logic                         rx_ready,
  output logic                         res_valid,
  output logic [COMMIT_RING_WIDTH-1:0] res_tag,
  output logic [31:0]                  res_data,
  input  logic                         res_grant,
  input  logic                         commit,
  input  logic                         flush,
  output logic                         rx_rollback,
  output logic [COMMIT_RING_WIDTH-1:0] rx_in_count
);

  localparam int W = COMMIT_RING_WIDTH;
  localparam logic [W-1:0] CNT_MAX = '1;

  in_ctrl_state_t state_q, state_d;
  logic [W-1:0]   tag_q;
  logic [31:0]    data_q;
  logic [W-1:0]   spec_count_q, spec_count_d;
  logic [W-1:0]   rx_in_count_q;
  logic           accept, pop, commit_ok;

  assign accept    = req_valid && req_ready;
  assign pop       = rx_valid && rx_ready;
  // A commit with nothing outstanding is ignored so the count cannot wrap.
  assign commit_ok = commit && (spec_count_q != '0);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; flush overrides every state, including ROLLBACK
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ROLLBACK;
    end else begin
      case (state_q)
        IDLE:     if (accept)    state_d = WAIT_RX;
        WAIT_RX:  if (pop)       state_d = RESULT;
        RESULT:   if (res_grant) state_d = IDLE;
        ROLLBACK:                state_d = IDLE;
        default:                 state_d = IDLE;
      endcase
    end
  end

  // Output logic; flush masks both handshakes in the same cycle
  always_comb begin
    req_ready   = 1'b0;
    rx_ready    = 1'b0;
    res_valid   = 1'b0;
    rx_rollback = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE:     req_ready   = !flush && (spec_count_q != CNT_MAX);
        WAIT_RX:  rx_ready    = !flush;
        RESULT:   res_valid   = 1'b1;
        ROLLBACK: rx_rollback = 1'b1;
        default:  ;
      endcase
    end
  end

  assign res_tag     = tag_q;
  assign res_data    = data_q;
  assign rx_in_count = rx_in_count_q;

  // Speculative count: a same-cycle pop and commit cancel out
  always_comb begin
    spec_count_d = spec_count_q;
    if (flush) begin
      spec_count_d = '0;
    end else if (pop && !commit_ok) begin
      spec_count_d = spec_count_q + 1'b1;
    end else if (!pop && commit_ok) begin
      spec_count_d = spec_count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_q         <= '0;
      data_q        <= '0;
      spec_count_q  <= '0;
      rx_in_count_q <= '0;
    end else begin
      spec_count_q <= spec_count_d;
      if (accept) tag_q  <= req_tag;
      if (pop)    data_q <= rx_data;
      // A commit in the flush cycle retires an older read, so it is not
      // rewound. A second flush during ROLLBACK sees a cleared count.
      if (flush) rx_in_count_q <= commit_ok ? spec_count_q - 1'b1 : spec_count_q;
    end
  end

  a_commit_underflow: assert property (@(posedge clk) disable iff (reset)
    commit |-> (spec_count_q != '0));

  a_res_rx_exclusive: assert property (@(posedge clk)
    !(res_valid && rx_ready));

  // Only a back-to-back flush may stretch the rollback pulse.
  a_rollback_pulse: assert property (@(posedge clk) disable iff (reset)
    (rx_rollback && !flush) |=> !rx_rollback);

endmodule

// File: tb/tb_in_controller.sv
module tb_in_controller;

  localparam int W = in_controller_pkg::DEFAULT_COMMIT_RING_WIDTH;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (default width)
  logic          reset, req_valid, req_ready, rx_valid, rx_ready;
  logic          res_valid, res_grant, commit, flush, rx_rollback;
  logic [W-1:0]  req_tag, res_tag, rx_in_count;
  logic [31:0]   rx_data, res_data;

  // Saturation instance (width 2)
  logic          s_reset, s_req_valid, s_req_ready, s_rx_valid, s_rx_ready;
  logic          s_res_valid, s_res_grant, s_commit, s_flush, s_rx_rollback;
  logic [1:0]    s_req_tag, s_res_tag, s_rx_in_count;
  logic [31:0]   s_rx_data, s_res_data;

  int n_tests = 0;
  int n_fail  = 0;

  in_controller u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_tag(req_tag), .req_ready(req_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .res_valid(res_valid), .res_tag(res_tag), .res_data(res_data),
    .res_grant(res_grant), .commit(commit), .flush(flush),
    .rx_rollback(rx_rollback), .rx_in_count(rx_in_count)
  );

  in_controller #(.COMMIT_RING_WIDTH(2)) u_sat (
    .clk(clk), .reset(s_reset),
    .req_valid(s_req_valid), .req_tag(s_req_tag), .req_ready(s_req_ready),
    .rx_data(s_rx_data), .rx_valid(s_rx_valid), .rx_ready(s_rx_ready),
    .res_valid(s_res_valid), .res_tag(s_res_tag), .res_data(s_res_data),
    .res_grant(s_res_grant), .commit(s_commit), .flush(s_flush),
    .rx_rollback(s_rx_rollback), .rx_in_count(s_rx_in_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete read on the main instance; returns the word seen on res_data.
  task automatic do_read(input logic [W-1:0] tag, input logic [31:0] word,
                         output logic [31:0] got);
    req_valid = 1'b1; req_tag = tag;
    tick();
    req_valid = 1'b0;
    rx_valid = 1'b1; rx_data = word;
    tick();
    rx_valid = 1'b0;
    got = res_data;
    res_grant = 1'b1;
    tick();
    res_grant = 1'b0;
  endtask

  task automatic test_reset();
    tick(); tick();
    n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
    n_tests++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL rst_rx_ready: got %b want 0", rx_ready); end
    n_tests++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL rst_res_valid: got %b want 0", res_valid); end
    n_tests++; if (rx_rollback !== 1'b0) begin n_fail++; $display("FAIL rst_rollback: got %b want 0", rx_rollback); end
    n_tests++; if (res_data !== 32'h0 || res_tag !== '0) begin n_fail++; $display("FAIL rst_res: got tag %0h data %0h want 0 0", res_tag, res_data); end
    reset = 1'b0; s_reset = 1'b0;
    #1;
    n_tests++; if (rx_in_count !== '0 || rx_rollback !== 1'b0 || res_valid !== 1'b0) begin n_fail++; $display("FAIL post_rst_outs: got cnt %0d rb %b rv %b want 0 0 0", rx_in_count, rx_rollback, res_valid); end
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_req_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_single_read();
    req_valid = 1'b1; req_tag = 4'd5; rx_valid = 1'b1; rx_data = 32'hDEADBEEF;
    #1;
    n_tests++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL sr_idle_no_pop: got %b want 0", rx_ready); end
    tick();
    req_valid = 1'b0;
    #1;
    n_tests++; if (rx_ready !== 1'b1 || res_valid !== 1'b0) begin n_fail++; $display("FAIL sr_wait: got rdy %b vld %b want 1 0", rx_ready, res_valid); end
    tick();
    rx_valid = 1'b0;
    #1;
    n_tests++; if (res_valid !== 1'b1 || res_tag !== 4'd5 || res_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sr_result: got vld %b tag %0d data %h want 1 5 deadbeef", res_valid, res_tag, res_data); end
    n_tests++; if (rx_ready !== 1'b0 || req_ready !== 1'b0) begin n_fail++; $display("FAIL sr_result_busy: got rx %b req %b want 0 0", rx_ready, req_ready); end
    tick(); tick();
    n_tests++; if (res_valid !== 1'b1 || res_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sr_hold: got vld %b data %h want 1 deadbeef", res_valid, res_data); end
    res_grant = 1'b1;
    tick();
    res_grant = 1'b0;
    n_tests++; if (res_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL sr_granted: got vld %b req %b want 0 1", res_valid, req_ready); end
    // One outstanding word; a flush now would rewind 1.
    flush = 1'b1;
    #1;
    n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL sr_flush_req_ready: got %b want 0", req_ready); end
    tick();
    flush = 1'b0;
    n_tests++; if (rx_rollback !== 1'b1 || rx_in_count !== 4'd1) begin n_fail++; $display("FAIL sr_count_one: got rb %b cnt %0d want 1 1", rx_rollback, rx_in_count); end
    tick();
    // Re-read, commit, then flush: nothing left to rewind.
    begin
      logic [31:0] got;
      do_read(4'd5, 32'hDEADBEEF, got);
    end
    commit = 1'b1;
    tick();
    commit = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_tests++; if (rx_rollback !== 1'b1 || rx_in_count !== 4'd0 || rx_ready !== 1'b0) begin n_fail++; $display("FAIL sr_commit_zero: got rb %b cnt %0d rx %b want 1 0 0", rx_rollback, rx_in_count, rx_ready); end
    tick();
    n_tests++; if (rx_rollback !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL sr_rb_end: got rb %b req %b want 0 1", rx_rollback, req_ready); end
  endtask

  task automatic test_empty_buffer();
    req_valid = 1'b1; req_tag = 4'd2; rx_valid = 1'b0;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      n_tests++; if (rx_ready !== 1'b1 || res_valid !== 1'b0) begin n_fail++; $display("FAIL eb_wait%0d: got rdy %b vld %b want 1 0", i, rx_ready, res_valid); end
      tick();
    end
    rx_valid = 1'b1; rx_data = 32'h12345678;
    tick();
    rx_valid = 1'b0;
    n_tests++; if (res_valid !== 1'b1 || res_tag !== 4'd2 || res_data !== 32'h12345678) begin n_fail++; $display("FAIL eb_result: got vld %b tag %0d data %h want 1 2 12345678", res_valid, res_tag, res_data); end
    res_grant = 1'b1;
    tick();
    res_grant = 1'b0; commit = 1'b1;
    tick();
    commit = 1'b0;
  endtask

  task automatic test_flush_rollback();
    logic [31:0] words [4];
    logic [31:0] got;
    int ptr;
    words[0] = 32'h11111111; words[1] = 32'h22222222;
    words[2] = 32'h33333333; words[3] = 32'h44444444;
    for (int i = 0; i < 3; i++) begin
      do_read(4'(i + 8), words[i], got);
      n_tests++; if (got !== words[i]) begin n_fail++; $display("FAIL fr_read%0d: got %h want %h", i, got, words[i]); end
    end
    commit = 1'b1;
    tick();
    commit = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    n_tests++; if (rx_rollback !== 1'b1 || rx_in_count !== 4'd2) begin n_fail++; $display("FAIL fr_rollback: got rb %b cnt %0d want 1 2", rx_rollback, rx_in_count); end
    // Buffer pointer after the rewind, as receiver_wrapper would compute it.
    ptr = 3 - int'(rx_in_count);
    if (ptr < 0 || ptr > 3) ptr = 0;
    tick();
    do_read(4'd1, words[ptr], got);
    n_tests++; if (got !== words[1]) begin n_fail++; $display("FAIL fr_replay: got %h want %h", got, words[1]); end
  endtask

  task automatic test_commit_in_flush();
    logic [31:0] got;
    // One word outstanding from the replay; two more make three.
    do_read(4'd3, 32'hA0A0A0A0, got);
    do_read(4'd4, 32'hB0B0B0B0, got);
    commit = 1'b1; flush = 1'b1;
    tick();
    commit = 1'b0; flush = 1'b0;
    n_tests++; if (rx_rollback !== 1'b1 || rx_in_count !== 4'd2) begin n_fail++; $display("FAIL cf_count: got rb %b cnt %0d want 1 2", rx_rollback, rx_in_count); end
    tick();
  endtask

  task automatic test_flush_wait_rx();
    logic [31:0] got;
    do_read(4'd6, 32'hC0C0C0C0, got);
    req_valid = 1'b1; req_tag = 4'd7;
    tick();
    req_valid = 1'b0; rx_valid = 1'b1; rx_data = 32'hBAD0BAD0; flush = 1'b1;
    #1;
    n_tests++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL fw_no_pop: got %b want 0", rx_ready); end
    tick();
    flush = 1'b0;
    n_tests++; if (rx_rollback !== 1'b1 || rx_in_count !== 4'd1 || res_valid !== 1'b0 || rx_ready !== 1'b0) begin n_fail++; $display("FAIL fw_rollback: got rb %b cnt %0d vld %b rx %b want 1 1 0 0", rx_rollback, rx_in_count, res_valid, rx_ready); end
    tick();
    n_tests++; if (res_valid !== 1'b0 || rx_rollback !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL fw_after: got vld %b rb %b req %b want 0 0 1", res_valid, rx_rollback, req_ready); end
    rx_valid = 1'b0;
  endtask

  task automatic test_flush_result_and_double();
    req_valid = 1'b1; req_tag = 4'd3;
    tick();
    req_valid = 1'b0; rx_valid = 1'b1; rx_data = 32'h0F0F0F0F;
    tick();
    rx_valid = 1'b0;
    flush = 1'b1; res_grant = 1'b1;
    tick();
    n_tests++; if (res_valid !== 1'b0 || rx_rollback !== 1'b1 || rx_in_count !== 4'd1) begin n_fail++; $display("FAIL fd_drop: got vld %b rb %b cnt %0d want 0 1 1", res_valid, rx_rollback, rx_in_count); end
    // Second flush while already rolling back: one more cycle, nothing left.
    tick();
    flush = 1'b0; res_grant = 1'b0;
    n_tests++; if (rx_rollback !== 1'b1 || rx_in_count !== 4'd0) begin n_fail++; $display("FAIL fd_double: got rb %b cnt %0d want 1 0", rx_rollback, rx_in_count); end
    tick();
    n_tests++; if (rx_rollback !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL fd_end: got rb %b req %b want 0 1", rx_rollback, req_ready); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 3; i++) begin
      s_req_valid = 1'b1; s_req_tag = 2'(i);
      #1;
      n_tests++; if (s_req_ready !== 1'b1) begin n_fail++; $display("FAIL sat_accept%0d: got %b want 1", i, s_req_ready); end
      tick();
      s_req_valid = 1'b0; s_rx_valid = 1'b1; s_rx_data = 32'(i);
      tick();
      s_rx_valid = 1'b0; s_res_grant = 1'b1;
      tick();
      s_res_grant = 1'b0;
    end
    s_req_valid = 1'b1;
    #1;
    n_tests++; if (s_req_ready !== 1'b0) begin n_fail++; $display("FAIL sat_stall: got %b want 0", s_req_ready); end
    tick();
    s_req_valid = 1'b0;
    n_tests++; if (s_rx_ready !== 1'b0) begin n_fail++; $display("FAIL sat_not_taken: got %b want 0", s_rx_ready); end
    s_commit = 1'b1;
    tick();
    s_commit = 1'b0;
    n_tests++; if (s_req_ready !== 1'b1) begin n_fail++; $display("FAIL sat_release: got %b want 1", s_req_ready); end
    // Commit and pop together: count must stay at 2.
    s_req_valid = 1'b1;
    tick();
    s_req_valid = 1'b0; s_rx_valid = 1'b1; s_rx_data = 32'h5A5A5A5A; s_commit = 1'b1;
    tick();
    s_rx_valid = 1'b0; s_commit = 1'b0;
    n_tests++; if (s_res_valid !== 1'b1 || s_res_data !== 32'h5A5A5A5A) begin n_fail++; $display("FAIL sat_pop: got vld %b data %h want 1 5a5a5a5a", s_res_valid, s_res_data); end
    s_res_grant = 1'b1;
    tick();
    s_res_grant = 1'b0;
    n_tests++; if (s_req_ready !== 1'b1) begin n_fail++; $display("FAIL sat_unchanged_ready: got %b want 1", s_req_ready); end
    s_flush = 1'b1;
    tick();
    s_flush = 1'b0;
    n_tests++; if (s_rx_rollback !== 1'b1 || s_rx_in_count !== 2'd2) begin n_fail++; $display("FAIL sat_count: got rb %b cnt %0d want 1 2", s_rx_rollback, s_rx_in_count); end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_tag = '0; rx_data = '0; rx_valid = 1'b0;
    res_grant = 1'b0; commit = 1'b0; flush = 1'b0;
    s_reset = 1'b1; s_req_valid = 1'b0; s_req_tag = '0; s_rx_data = '0; s_rx_valid = 1'b0;
    s_res_grant = 1'b0; s_commit = 1'b0; s_flush = 1'b0;
    test_reset();
    test_single_read();
    test_empty_buffer();
    test_flush_rollback();
    test_commit_in_flush();
    test_flush_wait_rx();
    test_flush_result_and_double();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
